// File: rtl/spi_write_arbiter.sv
// -----------------------------------------------------------------------------
// spi_write_arbiter
//
// Shares one chip-select framed, MSB-first byte serializer between two
// requesters. Pending requests are arbitrated round-robin in IDLE, and the
// winner's byte is latched. ser_csn is then held low for exactly FRAME_CYCLES
// cycles. When the frame ends, the winner gets a one-cycle ack, and ser_csn
// stays high for a GAP_CYCLES inter-frame gap before the next grant.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req0/req1   write requests, held high until the matching ack
//   data0/data1 request bytes, sampled only in the grant cycle
//   ack0/ack1   one-cycle frame-complete pulses (never both high)
//   ser_csn     serializer chip select, low while a frame is active
//   ser_data    serializer byte, stable for the whole frame
//   busy        high whenever the arbiter is not idle
//   grant       id of the requester owning the current or last frame
//   frame_count completed frames, wraps at 16 bits
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module spi_write_arbiter #(
    parameter int FRAME_CYCLES = 9,   // 9..255
    parameter int GAP_CYCLES   = 2    // 1..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [7:0]  data0,
    input  logic        req1,
    input  logic [7:0]  data1,
    output logic        ack0,
    output logic        ack1,
    output logic        ser_csn,
    output logic [7:0]  ser_data,
    output logic        busy,
    output logic        grant,
    output logic [15:0] frame_count
);

    localparam logic [7:0] FRAME_LAST = 8'(FRAME_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state_reg,       state_next;
    logic [7:0]  cnt_reg,         cnt_next;
    logic [7:0]  ser_data_reg,    ser_data_next;
    logic        ser_csn_reg,     ser_csn_next;
    logic [1:0]  ack_reg,         ack_next;
    logic        busy_reg,        busy_next;
    logic        grant_reg,       grant_next;
    logic        last_grant_reg,  last_grant_next;
    logic [15:0] frame_count_reg, frame_count_next;

    // Round-robin winner: a lone request wins outright; on a tie the
    // requester that did not own the previous frame wins.
    logic any_req;
    logic win_id;

    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            win_id = ~last_grant_reg;
        end else begin
            win_id = req1;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        ser_data_next    = ser_data_reg;
        ser_csn_next     = ser_csn_reg;
        ack_next         = 2'b00;      // acks are single-cycle pulses
        busy_next        = busy_reg;
        grant_next       = grant_reg;
        last_grant_next  = last_grant_reg;
        frame_count_next = frame_count_reg;

        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    ser_data_next   = win_id ? data1 : data0;
                    grant_next      = win_id;
                    last_grant_next = win_id;
                    ser_csn_next    = 1'b0;
                    busy_next       = 1'b1;
                    cnt_next        = 8'd0;
                    state_next      = SHIFT;
                end
            end

            SHIFT: begin
                // Byte and owner are frozen here; requester inputs are ignored
                // until the arbiter is back in IDLE.
                if (cnt_reg == FRAME_LAST) begin
                    ser_csn_next          = 1'b1;
                    ack_next[grant_reg]   = 1'b1;
                    frame_count_next      = frame_count_reg + 16'd1;
                    cnt_next              = 8'd0;
                    state_next            = GAP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end

            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    busy_next  = 1'b0;
                    cnt_next   = 8'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end

            default: begin
                ser_csn_next = 1'b1;
                busy_next    = 1'b0;
                cnt_next     = 8'd0;
                state_next   = IDLE;
            end
        endcase
    end

    // Asynchronous reset pulls ser_csn high immediately, aborting any frame
    // in flight without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= 8'd0;
            ser_data_reg    <= 8'h00;
            ser_csn_reg     <= 1'b1;
            ack_reg         <= 2'b00;
            busy_reg        <= 1'b0;
            grant_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;   // requester 0 wins the first tie
            frame_count_reg <= 16'd0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            ser_data_reg    <= ser_data_next;
            ser_csn_reg     <= ser_csn_next;
            ack_reg         <= ack_next;
            busy_reg        <= busy_next;
            grant_reg       <= grant_next;
            last_grant_reg  <= last_grant_next;
            frame_count_reg <= frame_count_next;
        end
    end

    assign ack0        = ack_reg[0];
    assign ack1        = ack_reg[1];
    assign ser_csn     = ser_csn_reg;
    assign ser_data    = ser_data_reg;
    assign busy        = busy_reg;
    assign grant       = grant_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_spi_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_write_arbiter
//
// Scenario tasks drive requests and push the frames they expect (owner and
// byte, chosen by a small round-robin model) onto a scoreboard queue. Each
// observed ack pops one entry, which is then compared against what was seen
// on ser_csn/ser_data during the frame.
// -----------------------------------------------------------------------------
module tb_spi_write_arbiter;

    localparam int FRAME = 9;
    localparam int GAP   = 2;
    localparam int TMO   = 40;

    logic        clk;
    logic        rst_n;
    logic        req0;
    logic [7:0]  data0;
    logic        req1;
    logic [7:0]  data1;
    logic        ack0;
    logic        ack1;
    logic        ser_csn;
    logic [7:0]  ser_data;
    logic        busy;
    logic        grant;
    logic [15:0] frame_count;

    spi_write_arbiter #(
        .FRAME_CYCLES (FRAME),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .data0       (data0),
        .req1        (req1),
        .data1       (data1),
        .ack0        (ack0),
        .ack1        (ack1),
        .ser_csn     (ser_csn),
        .ser_data    (ser_data),
        .busy        (busy),
        .grant       (grant),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    logic        lg;            // model of the last granted requester
    logic [15:0] exp_fc;        // model of frame_count

    // Length of the most recent ser_csn-high stretch between two frames.
    int hi_run;
    int last_gap;

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_run   <= 0;
            last_gap <= 0;
        end else if (ser_csn) begin
            hi_run <= hi_run + 1;
        end else if (hi_run != 0) begin
            last_gap <= hi_run;
            hi_run   <= 0;
        end
    end

    function automatic logic pick(input logic r0, input logic r1);
        if (r0 && r1) return ~lg;
        return r1;
    endfunction

    task automatic push_exp(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1);
        exp_t x;
        x.id   = pick(r0, r1);
        x.data = x.id ? d1 : d0;
        lg     = x.id;
        sb.push_back(x);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        lg     = 1'b1;
        exp_fc = 16'd0;
        sb.delete();
        @(negedge clk);
    endtask

    // Watches one frame up to its ack. Optionally rewrites data0 at a given
    // sample to show that mid-frame input changes are ignored.
    task automatic wait_ack(input int chg_cyc, input logic [7:0] chg_val,
                            output bit ok, output int cycles, output logic id,
                            output logic both, output logic [7:0] fdata,
                            output bit stable, output int low_cnt);
        bit started;
        ok = 0; cycles = 0; id = 1'bx; both = 1'b0; fdata = 8'hxx;
        stable = 1; low_cnt = 0; started = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            cycles++;
            if (ser_csn === 1'b0) begin
                if (!started) begin
                    fdata   = ser_data;
                    started = 1;
                end else if (ser_data !== fdata) begin
                    stable = 0;
                end
                low_cnt++;
            end
            if (cycles == chg_cyc) data0 = chg_val;
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                ok   = 1;
                id   = ack1;
                both = ack0 & ack1;
                break;
            end
        end
    endtask

    bit         ok;
    int         cyc;
    logic       aid;
    logic       both;
    logic [7:0] fdata;
    bit         stable;
    int         low_cnt;

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({ser_csn, ser_data, ack0, ack1, busy} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got csn=%0b data=%02h ack0=%0b ack1=%0b busy=%0b, required csn=1 data=00 ack0=0 ack1=0 busy=0",
                     ser_csn, ser_data, ack0, ack1, busy);
        end
        checks++;
        if ({grant, frame_count} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_grant_count: got grant=%0b count=%04h, required grant=0 count=0000", grant, frame_count);
        end
        rst_n = 1'b1; lg = 1'b1; exp_fc = 16'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ser_csn, busy, frame_count} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_idle_hold: got csn=%0b busy=%0b count=%04h, required csn=1 busy=0 count=0000",
                     ser_csn, busy, frame_count);
        end
    endtask

    task automatic test_single();
        push_exp(1'b1, 1'b0, 8'hA5, 8'h00);
        data0 = 8'hA5; req0 = 1'b1;
        wait_ack(0, 8'h00, ok, cyc, aid, both, fdata, stable, low_cnt);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_ack_timeout: got no ack, required ack within %0d cycles", TMO);
        end else begin
            req0 = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({both, aid, fdata} !== {1'b0, e.id, e.data}) begin
                errors++;
                $display("FAIL single_frame: got both=%0b id=%0d data=%02h, required both=0 id=%0d data=%02h", both, aid, fdata, e.id, e.data);
            end
            checks++;
            if (low_cnt !== FRAME || !stable || ser_csn !== 1'b1) begin
                errors++;
                $display("FAIL single_csn: got low=%0d stable=%0b csn=%0b, required low=%0d stable=1 csn=1", low_cnt, stable, ser_csn, FRAME);
            end
            checks++;
            if (cyc !== FRAME + 1) begin
                errors++;
                $display("FAIL single_latency: got ack after %0d edges, required %0d", cyc, FRAME + 1);
            end
            exp_fc++;
            checks++;
            if ({frame_count, grant, busy} !== {exp_fc, e.id, 1'b1}) begin
                errors++;
                $display("FAIL single_status: got count=%0d grant=%0d busy=%0b, required count=%0d grant=%0d busy=1", frame_count, grant, busy, exp_fc, e.id);
            end
            repeat (GAP) @(negedge clk);
            checks++;
            if ({busy, ack0, ack1} !== 3'b000) begin
                errors++;
                $display("FAIL single_idle: got busy=%0b ack0=%0b ack1=%0b, required 0 0 0", busy, ack0, ack1);
            end
        end
    endtask

    // Two requesters, each dropping its request after its own ack. The
    // predictions list which request lines are still up at each grant.
    task automatic run_pair(input string nm, input logic [7:0] d0, input logic [7:0] d1);
        push_exp(1'b1, 1'b1, d0, d1);
        push_exp(!lg ? 1'b0 : 1'b1, lg ? 1'b0 : 1'b1, d0, d1);
        data0 = d0; data1 = d1; req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_ack(0, 8'h00, ok, cyc, aid, both, fdata, stable, low_cnt);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s_ack_timeout: got no ack for frame %0d, required ack within %0d cycles", nm, k, TMO);
                break;
            end
            if (aid) req1 = 1'b0; else req0 = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({both, aid, fdata, grant} !== {1'b0, e.id, e.data, e.id}) begin
                errors++;
                $display("FAIL %s_frame%0d: got both=%0b id=%0d data=%02h grant=%0d, required both=0 id=%0d data=%02h grant=%0d",
                         nm, k, both, aid, fdata, grant, e.id, e.data, e.id);
            end
            checks++;
            if (low_cnt !== FRAME || !stable || ser_csn !== 1'b1) begin
                errors++;
                $display("FAIL %s_csn%0d: got low=%0d stable=%0b csn=%0b, required low=%0d stable=1 csn=1", nm, k, low_cnt, stable, ser_csn, FRAME);
            end
            exp_fc++;
            checks++;
            if (frame_count !== exp_fc) begin
                errors++;
                $display("FAIL %s_count%0d: got %0d, required %0d", nm, k, frame_count, exp_fc);
            end
        end
        checks++;
        if (last_gap !== GAP + 1) begin
            errors++;
            $display("FAIL %s_gap: got csn high %0d cycles, required %0d", nm, last_gap, GAP + 1);
        end
        repeat (GAP + 1) @(negedge clk);
    endtask

    task automatic test_tie();
        apply_reset();
        run_pair("tie", 8'h11, 8'h22);
    endtask

    task automatic test_contention();
        int p0, p1, n0, n1;
        apply_reset();
        p0 = 0; p1 = 0; n0 = 0; n1 = 0;
        for (int k = 0; k < 6; k++) begin
            push_exp(1'b1, 1'b1, 8'(8'hA0 + p0), 8'(8'hB0 + p1));
            if (lg) p1++; else p0++;
        end
        data0 = 8'hA0; data1 = 8'hB0; req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_ack(0, 8'h00, ok, cyc, aid, both, fdata, stable, low_cnt);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL contention_ack_timeout: got no ack for frame %0d, required ack within %0d cycles", k, TMO);
                break;
            end
            if (aid) begin n1++; data1 = 8'(8'hB0 + n1); end
            else     begin n0++; data0 = 8'(8'hA0 + n0); end
            if (k == 5) begin req0 = 1'b0; req1 = 1'b0; end
            e = sb.pop_front();
            checks++;
            if ({both, aid, fdata, grant} !== {1'b0, e.id, e.data, e.id}) begin
                errors++;
                $display("FAIL contention_frame%0d: got both=%0b id=%0d data=%02h grant=%0d, required both=0 id=%0d data=%02h grant=%0d",
                         k, both, aid, fdata, grant, e.id, e.data, e.id);
            end
            checks++;
            if (low_cnt !== FRAME || !stable) begin
                errors++;
                $display("FAIL contention_csn%0d: got low=%0d stable=%0b, required low=%0d stable=1", k, low_cnt, stable, FRAME);
            end
        end
        repeat (GAP + 2) @(negedge clk);
        checks++;
        if ({frame_count, busy} !== {16'd6, 1'b0}) begin
            errors++;
            $display("FAIL contention_total: got count=%0d busy=%0b, required count=6 busy=0", frame_count, busy);
        end
        exp_fc = frame_count;
    endtask

    task automatic test_data_stability();
        push_exp(1'b1, 1'b0, 8'h3C, 8'h00);
        data0 = 8'h3C; req0 = 1'b1;
        wait_ack(5, 8'hFF, ok, cyc, aid, both, fdata, stable, low_cnt);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stability_ack_timeout: got no ack, required ack within %0d cycles", TMO);
        end else begin
            req0 = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({aid, fdata, stable} !== {e.id, e.data, 1'b1}) begin
                errors++;
                $display("FAIL stability_frame: got id=%0d data=%02h stable=%0b, required id=%0d data=%02h stable=1", aid, fdata, stable, e.id, e.data);
            end
            checks++;
            if (ser_data !== 8'h3C) begin
                errors++;
                $display("FAIL stability_hold: got ser_data=%02h after frame, required 3c", ser_data);
            end
        end
        data0 = 8'h00;
        repeat (GAP + 1) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ack_seen;
        ack_seen = 0;
        data0 = 8'h55; req0 = 1'b1; req1 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack0 || ack1) ack_seen = 1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ser_csn, busy, frame_count} !== {1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL midreset_async: got csn=%0b busy=%0b count=%0d, required csn=1 busy=0 count=0", ser_csn, busy, frame_count);
        end
        req0 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack0 || ack1) ack_seen = 1;
        end
        rst_n = 1'b1; lg = 1'b1; exp_fc = 16'd0; sb.delete();
        repeat (2) begin
            @(negedge clk);
            if (ack0 || ack1) ack_seen = 1;
        end
        checks++;
        if (ack_seen || ser_csn !== 1'b1) begin
            errors++;
            $display("FAIL midreset_noack: got ack_seen=%0b csn=%0b, required ack_seen=0 csn=1", ack_seen, ser_csn);
        end
        run_pair("midreset", 8'h81, 8'h42);
    endtask

    // req1 alone while it already owns the last grant must still win, and a
    // request held through its ack starts a fresh frame after the gap.
    task automatic test_lone_requester();
        push_exp(1'b0, 1'b1, 8'h00, 8'hC3);
        push_exp(1'b0, 1'b1, 8'h00, 8'h3D);
        data1 = 8'hC3; req1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_ack(0, 8'h00, ok, cyc, aid, both, fdata, stable, low_cnt);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL lone_ack_timeout: got no ack for frame %0d, required ack within %0d cycles", k, TMO);
                break;
            end
            if (k == 0) data1 = 8'h3D; else req1 = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({both, aid, fdata, grant} !== {1'b0, e.id, e.data, e.id}) begin
                errors++;
                $display("FAIL lone_frame%0d: got both=%0b id=%0d data=%02h grant=%0d, required both=0 id=%0d data=%02h grant=%0d",
                         k, both, aid, fdata, grant, e.id, e.data, e.id);
            end
            exp_fc++;
            checks++;
            if (low_cnt !== FRAME || frame_count !== exp_fc) begin
                errors++;
                $display("FAIL lone_csn%0d: got low=%0d count=%0d, required low=%0d count=%0d", k, low_cnt, frame_count, FRAME, exp_fc);
            end
        end
        checks++;
        if (last_gap !== GAP + 1) begin
            errors++;
            $display("FAIL lone_gap: got csn high %0d cycles, required %0d", last_gap, GAP + 1);
        end
        repeat (GAP + 2) @(negedge clk);
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lone_drain: got pending=%0d busy=%0b, required pending=0 busy=0", sb.size(), busy);
        end
    endtask

    initial begin
        lg = 1'b1; exp_fc = 16'd0;
        test_reset();
        test_single();
        test_tie();
        test_contention();
        test_data_stability();
        test_reset_mid();
        test_lone_requester();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_write_arbiter.md
Name: spi_write_arbiter

Overview:
Shares one 8-bit serial write channel (chip-select framed, MSB-first byte serializer) between two requesters, e.g. ADC configuration and display update. It arbitrates round-robin and latches the winning byte. It drives the serializer's active-low chip-select low for exactly one frame, then enforces an inter-frame gap and acknowledges the requester. It sits between the requesters and the byte serializer that feeds the external pins.

Parameters:
FRAME_CYCLES, 9, cycles ser_csn is held low per frame; legal range 9..255; 9 = 8 bit cycles + 1 cycle for the serializer to release its CS.
GAP_CYCLES, 2, cycles ser_csn is held high after a frame before IDLE; legal range 1..255.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 write request; held high until ack0
data0  in  8  requester 0 byte; sampled only at grant
req1  in  1  requester 1 write request; held high until ack1
data1  in  8  requester 1 byte; sampled only at grant
ack0  out  1  one-cycle pulse: requester 0 frame complete
ack1  out  1  one-cycle pulse: requester 1 frame complete
ser_csn  out  1  to serializer csn_in; low = frame active
ser_data  out  8  to serializer data_in; stable for the whole frame
busy  out  1  high whenever state != IDLE
grant  out  1  id of the requester owning the current or last frame
frame_count  out  16  completed frames, wraps 0xFFFF->0x0000

Behaviour:
- Clock and reset: clk is the single clock; rst_n is asynchronous and active-low.
- Reset: state=IDLE, ser_csn=1, ser_data=0x00, ack0=ack1=0, busy=0, grant=0, frame_count=0, last_grant=1 (so req0 wins the first tie), cnt=0. All outputs are registered.
- Reset mid-frame forces ser_csn high at once. The serializer then restarts cleanly on its next clock. No ack is issued for the aborted frame.
- States: IDLE, SHIFT, GAP. cnt is 8-bit.
- IDLE, no request: hold all outputs; ack0=ack1=0.
- IDLE, request present, at the edge:
  - Pick the winner. Only one req high -> that one. Both high -> the id != last_grant.
  - ser_data <= winner's data; grant <= winner id; last_grant <= winner id.
  - ser_csn <= 0; busy <= 1; cnt <= 0; go to SHIFT.
- SHIFT:
  - cnt increments each edge. ser_data and grant are frozen; changes on data0/data1/req are ignored.
  - At the edge where cnt == FRAME_CYCLES-1: ser_csn <= 1; ack[grant] <= 1 for one cycle; frame_count <= frame_count+1; cnt <= 0; go to GAP.
  - Net effect: ser_csn is low for exactly FRAME_CYCLES cycles.
- GAP:
  - ser_csn stays high; ack cleared after one cycle; cnt increments.
  - At cnt == GAP_CYCLES-1: go to IDLE; busy <= 0.
- Requester rule: deassert req within GAP_CYCLES cycles after seeing ack. A req still high when IDLE is re-entered is a new request.
- Back-to-back: ser_csn is high for a minimum of GAP_CYCLES+1 cycles between frames (GAP plus the IDLE grant cycle).
- Latency from req rising in IDLE:
  - ser_csn falls 1 edge later.
  - ack pulses FRAME_CYCLES+1 edges after req.
- Fairness: with both requests continuously asserted, grants alternate strictly 0,1,0,1. Neither requester waits more than one frame.
- A req rising during SHIFT or GAP waits; it is evaluated in IDLE with the same round-robin rule.
- ack0 and ack1 are never high together.

Test Plan:
- Single request: req0=1, data0=0xA5 from IDLE -> ser_csn low for 9 cycles, ser_data=0xA5 throughout, serializer emits bits 1,0,1,0,0,1,0,1. ack0 pulses 1 cycle coincident with ser_csn rising; frame_count=1; grant=0.
- Tie after reset: req0=req1=1 (0x11, 0x22) held, each dropped after its ack -> frame 0x11 (grant 0) then 0x22 (grant 1). ser_csn high exactly 3 cycles between frames (GAP=2). ack0 then ack1, never overlapping.
- Sustained contention: both reqs re-asserted immediately after every ack for 6 frames -> grant sequence 0,1,0,1,0,1; frame_count=6.
- Data stability: data0 changes 0x3C->0xFF at SHIFT cycle 4 -> ser_data stays 0x3C and the serial stream equals 0x3C.
- Reset mid-frame: rst_n low at SHIFT cycle 5 for 2 cycles -> ser_csn=1 immediately, no ack, frame_count=0. A new req0=0x81 afterwards completes normally, with req0 winning.
- Counter wrap: 65536 single frames -> frame_count returns to 0x0000; arbitration unaffected.
